// File: rtl/neighbor_scan.sv
// Sequentially scans one event's 5x5 neighbour-index array, reads the pixel-state memory for each
// in-frame index and streams out node IDs of occupied neighbours that fall inside the time window.
module neighbor_scan #(
    parameter int TOT_PIXEL    = 12000,
    parameter int MAX_DS_RANGE = 25,
    parameter int TS_W         = 16,
    parameter int NODE_W       = 12,
    parameter int TS_WINDOW    = 1000,
    localparam int IDX_W  = $clog2(TOT_PIXEL) + 2,
    localparam int ADDR_W = $clog2(TOT_PIXEL),
    localparam int CNT_W  = $clog2(MAX_DS_RANGE + 1),
    localparam int MEM_W  = 1 + TS_W + NODE_W
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_DS_RANGE*IDX_W-1:0] neighbor_pixels,
    input  logic [TS_W-1:0]               cur_ts,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_rd_addr,
    input  logic [MEM_W-1:0]              mem_rd_data,
    output logic                          nb_valid,
    input  logic                          nb_ready,
    output logic [NODE_W-1:0]             nb_node_id,
    output logic                          done,
    output logic [CNT_W-1:0]              nb_count
);

    localparam int SEL_W = $clog2(MAX_DS_RANGE);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(MAX_DS_RANGE - 1);
    localparam logic [IDX_W-1:0] TOT_LIM  = IDX_W'(TOT_PIXEL);
    localparam logic [TS_W-1:0]  WIN_LIM  = TS_W'(TS_WINDOW);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WAIT, S_EMIT, S_DONE} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_array [MAX_DS_RANGE];
    logic [TS_W-1:0]     r_cur_ts;
    logic [SEL_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_hits;
    logic                r_in_ready;
    logic                r_mem_rd_en;
    logic [ADDR_W-1:0]   r_mem_rd_addr;
    logic                r_nb_valid;
    logic [NODE_W-1:0]   r_nb_node_id;
    logic                r_done;
    logic [CNT_W-1:0]    r_nb_count;

    logic [IDX_W-1:0]    w_in_entry [MAX_DS_RANGE];
    logic [IDX_W-1:0]    w_next_entry;
    logic                w_rd_occ;
    logic [TS_W-1:0]     w_rd_ts;
    logic [NODE_W-1:0]   w_rd_node;
    logic [TS_W-1:0]     w_age;
    logic                w_hit;
    logic                w_adv;
    logic [CNT_W-1:0]    w_hits_final;

    // Indices are signed: negative or past the frame means "no neighbour".
    function automatic logic f_in_range(input logic [IDX_W-1:0] e);
        return !e[IDX_W-1] && (e < TOT_LIM);
    endfunction

    generate
        for (genvar gi = 0; gi < MAX_DS_RANGE; gi++) begin : g_unpack
            assign w_in_entry[gi] = neighbor_pixels[gi*IDX_W +: IDX_W];
        end
    endgenerate

    always_comb begin
        w_next_entry = '1;
        if (r_idx != LAST_IDX) begin
            w_next_entry = r_array[r_idx + 1'b1];
        end
    end

    assign w_rd_occ  = mem_rd_data[MEM_W-1];
    assign w_rd_ts   = mem_rd_data[NODE_W +: TS_W];
    assign w_rd_node = mem_rd_data[NODE_W-1:0];
    assign w_age     = r_cur_ts - w_rd_ts;
    assign w_hit     = w_rd_occ && (w_age <= WIN_LIM);

    // In SCAN the read strobe doubles as the "current entry is in range" flag.
    assign w_adv = ((r_state == S_SCAN) && !r_mem_rd_en)
                || ((r_state == S_WAIT) && !w_hit)
                || ((r_state == S_EMIT) && nb_ready);
    assign w_hits_final = (r_state == S_EMIT) ? r_hits + 1'b1 : r_hits;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_cur_ts      <= '0;
            r_idx         <= '0;
            r_hits        <= '0;
            r_in_ready    <= 1'b1;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_nb_valid    <= 1'b0;
            r_nb_node_id  <= '0;
            r_done        <= 1'b0;
            r_nb_count    <= '0;
            for (int i = 0; i < MAX_DS_RANGE; i++) begin
                r_array[i] <= '0;
            end
        end else begin
            r_mem_rd_en <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        for (int i = 0; i < MAX_DS_RANGE; i++) begin
                            r_array[i] <= w_in_entry[i];
                        end
                        r_cur_ts   <= cur_ts;
                        r_idx      <= '0;
                        r_hits     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SCAN;
                        if (f_in_range(w_in_entry[0])) begin
                            r_mem_rd_en   <= 1'b1;
                            r_mem_rd_addr <= w_in_entry[0][ADDR_W-1:0];
                        end
                    end
                end
                S_SCAN: begin
                    if (r_mem_rd_en) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_hit) begin
                        r_nb_valid   <= 1'b1;
                        r_nb_node_id <= w_rd_node;
                        r_state      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (nb_ready) begin
                        r_nb_valid <= 1'b0;
                        r_hits     <= r_hits + 1'b1;
                    end
                end
                S_DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_adv) begin
                if (r_idx == LAST_IDX) begin
                    r_state    <= S_DONE;
                    r_done     <= 1'b1;
                    r_nb_count <= w_hits_final;
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_state <= S_SCAN;
                    if (f_in_range(w_next_entry)) begin
                        r_mem_rd_en   <= 1'b1;
                        r_mem_rd_addr <= w_next_entry[ADDR_W-1:0];
                    end
                end
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign nb_valid    = r_nb_valid;
    assign nb_node_id  = r_nb_node_id;
    assign done        = r_done;
    assign nb_count    = r_nb_count;

endmodule

// File: tb/tb_neighbor_scan.sv
// Scoreboard bench for neighbor_scan: directed events push expected reads, node IDs, counts and
// latencies into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_neighbor_scan;

    localparam int TOT    = 12000;
    localparam int NR     = 25;
    localparam int TS_W   = 16;
    localparam int NODE_W = 12;
    localparam int IDX_W  = 16;
    localparam int ADDR_W = 14;
    localparam int CNT_W  = 5;
    localparam int MEM_W  = 29;

    logic                   clk;
    logic                   rstn;
    logic                   in_valid;
    logic                   in_ready;
    logic [NR*IDX_W-1:0]    neighbor_pixels;
    logic [TS_W-1:0]        cur_ts;
    logic                   mem_rd_en;
    logic [ADDR_W-1:0]      mem_rd_addr;
    logic [MEM_W-1:0]       mem_rd_data;
    logic                   nb_valid;
    logic                   nb_ready;
    logic [NODE_W-1:0]      nb_node_id;
    logic                   done;
    logic [CNT_W-1:0]       nb_count;

    neighbor_scan dut (
        .clk             (clk),
        .rstn            (rstn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .neighbor_pixels (neighbor_pixels),
        .cur_ts          (cur_ts),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .nb_valid        (nb_valid),
        .nb_ready        (nb_ready),
        .nb_node_id      (nb_node_id),
        .done            (done),
        .nb_count        (nb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel-state memory model with one-cycle registered read.
    logic [MEM_W-1:0] mem [TOT];
    initial mem_rd_data = '0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    int checks = 0;
    int errors = 0;
    int accept_cyc = 0;
    int done_cnt = 0;
    int ent [NR];
    int exp_addr[$];
    int exp_node[$];
    int exp_cnt[$];
    int exp_lat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic flag(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected nothing", name, act);
    endtask

    // Monitor: every DUT presentation is matched against the scoreboard queues.
    logic prev_stall = 1'b0;
    logic prev_done  = 1'b0;
    logic [NODE_W-1:0] prev_id = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("nb_hold_valid", 32'(nb_valid), 32'd1);
                check("nb_hold_id", 32'(nb_node_id), 32'(prev_id));
            end
            if (mem_rd_en) begin
                if (exp_addr.size() == 0) flag("rd_addr_unexpected", int'(mem_rd_addr));
                else check("rd_addr", 32'(mem_rd_addr), 32'(exp_addr.pop_front()));
            end
            if (nb_valid && nb_ready) begin
                if (exp_node.size() == 0) flag("nb_node_unexpected", int'(nb_node_id));
                else check("nb_node_id", 32'(nb_node_id), 32'(exp_node.pop_front()));
            end
            if (done) begin
                done_cnt++;
                check("done_pulse_width", 32'(prev_done), 32'd0);
                if (exp_cnt.size() == 0) flag("done_unexpected", int'(nb_count));
                else begin
                    check("nb_count", 32'(nb_count), 32'(exp_cnt.pop_front()));
                    check("done_latency", 32'(cyc - accept_cyc), 32'(exp_lat.pop_front()));
                end
            end
            prev_stall = nb_valid && !nb_ready;
            prev_id    = nb_node_id;
            prev_done  = done;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < TOT; i++) mem[i] = '0;
    endtask

    task automatic set_pix(input int addr, input int ts, input int node);
        mem[addr] = {1'b1, TS_W'(ts), NODE_W'(node)};
    endtask

    task automatic fill_none();
        for (int i = 0; i < NR; i++) ent[i] = -1;
    endtask

    // 5x5 window in a 120x100 frame; x off-frame gives -1, y off-frame gives a linear index outside 0..11999.
    task automatic build_window(input int cx, input int cy);
        for (int i = 0; i < NR; i++) begin
            int x;
            int y;
            x = cx + (i % 5) - 2;
            y = cy + (i / 5) - 2;
            ent[i] = (x < 0 || x > 119) ? -1 : y * 120 + x;
        end
    endtask

    task automatic push_reads();
        for (int i = 0; i < NR; i++) begin
            if (ent[i] >= 0 && ent[i] < TOT) exp_addr.push_back(ent[i]);
        end
    endtask

    task automatic expect_done(input int cnt, input int lat);
        exp_cnt.push_back(cnt);
        exp_lat.push_back(lat);
    endtask

    task automatic send(input int ts);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) flag("in_ready_timeout", n);
        for (int i = 0; i < NR; i++) neighbor_pixels[i*IDX_W +: IDX_W] = IDX_W'(ent[i]);
        cur_ts     = TS_W'(ts);
        in_valid   = 1'b1;
        accept_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid        = 1'b0;
        neighbor_pixels = '1;
        cur_ts          = 16'hDEAD;
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 500) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (done_cnt == start) flag("done_timeout", n);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!nb_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!nb_valid) flag("nb_valid_timeout", n);
    endtask

    initial begin
        rstn            = 1'b0;
        in_valid        = 1'b0;
        nb_ready        = 1'b1;
        neighbor_pixels = '1;
        cur_ts          = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_nb_valid", 32'(nb_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_nb_count", 32'(nb_count), 32'd0);
        check("rst_mem_rd_addr", 32'(mem_rd_addr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // All entries invalid: no reads, done 26 cycles after accept.
        fill_none();
        expect_done(0, 26);
        send(0);
        wait_done();

        // Event (12,25): three occupied neighbours at entries 3, 12, 20.
        build_window(12, 25);
        clear_mem();
        set_pix(ent[3], 1990, 'h0A1);
        set_pix(ent[12], 1990, 'h5C3);
        set_pix(ent[20], 1990, 'hFFF);
        push_reads();
        exp_node.push_back('h0A1);
        exp_node.push_back('h5C3);
        exp_node.push_back('hFFF);
        expect_done(3, 54);
        send(2000);
        wait_done();

        // Same event with the consumer stalling 7 cycles on the first hit.
        push_reads();
        exp_node.push_back('h0A1);
        exp_node.push_back('h5C3);
        exp_node.push_back('hFFF);
        expect_done(3, 61);
        nb_ready = 1'b0;
        send(2000);
        wait_valid();
        repeat (7) @(posedge clk);
        #1;
        nb_ready = 1'b1;
        wait_done();

        // Corner (119,99): only the 9 in-frame pixels are read.
        build_window(119, 99);
        clear_mem();
        set_pix(11999, 300, 'h777);
        push_reads();
        exp_node.push_back('h777);
        expect_done(1, 36);
        send(300);
        wait_done();

        // Age boundaries: 1000 hits, 1001 misses, a future timestamp misses.
        clear_mem();
        fill_none();
        ent[0] = 100;
        ent[1] = 101;
        ent[2] = 103;
        set_pix(100, 4000, 'h100);
        set_pix(101, 3999, 'h101);
        set_pix(103, 5001, 'h103);
        exp_addr.push_back(100);
        exp_addr.push_back(101);
        exp_addr.push_back(103);
        exp_node.push_back('h100);
        expect_done(1, 30);
        send(5000);
        wait_done();

        // Timestamp wrap and range edges: 12000 and 32767 skipped, 11999 read.
        fill_none();
        ent[0]  = 12000;
        ent[1]  = 102;
        ent[2]  = 32767;
        ent[24] = 11999;
        set_pix(102, 65530, 'h102);
        exp_addr.push_back(102);
        exp_addr.push_back(11999);
        exp_node.push_back('h102);
        expect_done(1, 29);
        send(5);
        wait_done();

        // Reset while holding a hit in EMIT; that event must vanish.
        clear_mem();
        fill_none();
        ent[0] = 500;
        set_pix(500, 90, 'h050);
        exp_addr.push_back(500);
        nb_ready = 1'b0;
        send(100);
        wait_valid();
        #2;
        rstn = 1'b0;
        #1;
        check("abort_nb_valid", 32'(nb_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_mem_rd_en", 32'(mem_rd_en), 32'd0);
        @(negedge clk);
        rstn     = 1'b1;
        nb_ready = 1'b1;

        fill_none();
        ent[0] = 600;
        ent[1] = 601;
        set_pix(600, 190, 'h03C);
        set_pix(601, 195, 'h03D);
        exp_addr.push_back(600);
        exp_addr.push_back(601);
        exp_node.push_back('h03C);
        exp_node.push_back('h03D);
        expect_done(2, 30);
        send(200);
        wait_done();

        repeat (5) @(negedge clk);
        #1;
        check("left_reads", 32'(exp_addr.size()), 32'd0);
        check("left_nodes", 32'(exp_node.size()), 32'd0);
        check("left_dones", 32'(exp_cnt.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
